stream_nasti_mover_sched: RTL and testbench

Round-robin scheduler that shares one stream-to-NASTI data mover among `N_REQ` requesters.

- Accepts destination-address requests and rejects misaligned ones.
- Issues each accepted request on the mover's `r_dest`/`r_valid`/`r_ready` port and tracks completion through the mover's return to idle.
- Drives a one-hot grant that selects the owning requester's stream into the mover's `src` channel, and pulses per-requester done/error.
- Sits between DMA client logic and the mover.

---
 rtl/stream_nasti_mover_sched.sv | 166 ++++++++++++++++
 tb/tb_stream_nasti_mover_sched.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_nasti_mover_sched.sv
// Round-robin scheduler sharing one stream-to-NASTI mover among N_REQ
// requesters; issues aligned destinations and pulses done/err per owner.
module stream_nasti_mover_sched #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            done,
  output logic [N_REQ-1:0]            err,
  output logic [ADDR_WIDTH-1:0]       mv_dest,
  output logic                        mv_valid,
  input  logic                        mv_ready,
  output logic [N_REQ-1:0]            grant,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        timeout,
  input  logic                        timeout_clr
);

  localparam int IW = $clog2(N_REQ);
  localparam int AB = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(AB - 1);
  localparam logic [CW-1:0]         CMAX  = CW'(TIMEOUT);
  localparam logic [N_REQ-1:0]      ONE   = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d;
  logic [ADDR_WIDTH-1:0]   dest_q, dest_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [IW-1:0]           gid_q, gid_d;
  logic [N_REQ-1:0]        done_q, done_d;
  logic [N_REQ-1:0]        err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    tmo_q, tmo_d;

  logic                    win_any;
  logic [IW-1:0]           win_id;
  logic [N_REQ-1:0]        win_oh;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    misal;
  logic                    tmo_set;

  // Search starts one past the previous winner so every requester
  // gets a turn before anyone is served twice.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N_REQ;
      if (!win_any && req_valid[idx]) begin
        win_any = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  assign win_oh   = win_any ? (ONE << win_id) : '0;
  assign win_addr = req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign misal    = |(win_addr & AMASK);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dest_d  = dest_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    done_d  = '0;
    err_d   = '0;
    cnt_d   = cnt_q;
    tmo_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        gid_d   = '0;
        if (win_any) begin
          last_d = win_id;
          if (misal) begin
            err_d = win_oh;
          end else begin
            state_d = S_ISSUE;
            dest_d  = win_addr;
            grant_d = win_oh;
            gid_d   = win_id;
          end
        end
      end
      S_ISSUE: begin
        if (mv_ready) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        // Flag only on the step onto TIMEOUT so a clear sticks.
        if (cnt_q != CMAX) begin
          cnt_d   = cnt_q + 1'b1;
          tmo_set = (cnt_d == CMAX);
        end
        if (mv_ready) begin
          done_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmo_d = tmo_q;
    if (tmo_set) begin
      tmo_d = 1'b1;
    end else if (timeout_clr) begin
      tmo_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ - 1);
      dest_q  <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) ? win_oh : '0;
  assign mv_valid  = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign mv_dest   = dest_q;
  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_stream_nasti_mover_sched.sv
// Bench for stream_nasti_mover_sched: directed scenarios plus a random
// run checked against a transaction-level round-robin model.
module tb_stream_nasti_mover_sched;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int TO = 16;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    done;
  logic [N-1:0]    err;
  logic [AW-1:0]   mv_dest;
  logic            mv_valid;
  logic            mv_ready = 1'b1;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout;
  logic            timeout_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  int mv_lat  = 2;
  bit mv_rand = 1'b0;
  bit mv_hold = 1'b0;
  int mv_cnt  = 0;
  bit fire_pend;

  stream_nasti_mover_sched #(
    .N_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(64), .TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .done(done), .err(err),
    .mv_dest(mv_dest), .mv_valid(mv_valid),
    .mv_ready(mv_ready), .grant(grant),
    .grant_id(grant_id), .busy(busy),
    .timeout(timeout), .timeout_clr(timeout_clr)
  );

  initial forever #5 aclk = ~aclk;

  // Mover model: idle-ready, drops ready after fire for a latency.
  initial begin
    forever begin
      @(negedge aclk);
      fire_pend = mv_valid && mv_ready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        mv_cnt = 0;
        mv_ready = 1'b1;
      end else if (fire_pend) begin
        mv_cnt = mv_rand ? int'($urandom_range(1, 6)) : mv_lat;
        mv_ready = 1'b0;
      end else if (mv_cnt > 0) begin
        mv_cnt--;
        if (mv_cnt == 0) mv_ready = 1'b1;
      end else begin
        mv_ready = !mv_hold;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [63:0] a,
                         input bit v);
    req_addr[i*AW +: AW] = a;
    req_valid[i] = v;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: busy=%b after %0d cyc, want 0", busy, n);
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if (req_ready !== '0 || done !== '0 || err !== '0) begin
      errors++;
      $display("FAIL rst_pulses: rdy=%b done=%b err=%b want 0",
               req_ready, done, err);
    end
    checks++;
    if (mv_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: v=%b b=%b t=%b want 0",
               mv_valid, busy, timeout);
    end
    checks++;
    if (grant !== '0 || grant_id !== '0 || mv_dest !== '0) begin
      errors++;
      $display("FAIL rst_regs: g=%b id=%0d d=%h want 0",
               grant, grant_id, mv_dest);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_all_rr();
    int k = 0;
    int nd = 0;
    int n = 0;
    int own = 0;
    mv_lat = 3;
    for (int i = 0; i < N; i++) set_req(i, 64'h100 * (i + 1), 1'b1);
    while (k < 5 && n < 400) begin
      #1;
      if (done !== '0) begin
        checks++;
        if (done !== 4'(1 << own)) begin
          errors++;
          $display("FAIL rr_done: done=%b want %b", done, 4'(1 << own));
        end
        nd++;
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL rr_grant: grant=%b want one-hot", grant);
      end
      if (req_ready !== '0) begin
        checks++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          errors++;
          $display("FAIL rr_order: rdy=%b want %b",
                   req_ready, 4'(1 << (k % 4)));
        end
        own = k % 4;
        k++;
      end
      @(negedge aclk);
      n++;
    end
    req_valid = '0;
    checks++;
    if (k != 5 || nd != 4) begin
      errors++;
      $display("FAIL rr_count: accepts=%0d dones=%0d want 5/4", k, nd);
    end
    drain();
  endtask

  task automatic test_single();
    int n = 0;
    mv_lat = 20;
    set_req(2, 64'h1000, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_rdy: rdy=%b want 0100", req_ready);
    end
    @(negedge aclk);
    req_valid = '0;
    checks++;
    if (mv_valid !== 1'b1 || mv_dest !== 64'h1000) begin
      errors++;
      $display("FAIL single_issue: v=%b d=%h want 1/1000",
               mv_valid, mv_dest);
    end
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: g=%b id=%0d want 0100/2",
               grant, grant_id);
    end
    while (done === '0 && n < 100) begin
      checks++;
      if (grant !== 4'b0100) begin
        errors++;
        $display("FAIL single_hold: g=%b want 0100", grant);
      end
      @(negedge aclk);
      n++;
    end
    checks++;
    if (done !== 4'b0100 || busy !== 1'b0 || n != 22) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b cyc=%0d want 0100/0/22",
               done, busy, n);
    end
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_gdone: g=%b want 0100", grant);
    end
    @(negedge aclk);
    checks++;
    if (done !== '0 || grant !== '0) begin
      errors++;
      $display("FAIL single_after: done=%b g=%b want 0/0", done, grant);
    end
    timeout_clr = 1'b1;
    @(negedge aclk);
    timeout_clr = 1'b0;
  endtask

  task automatic test_misaligned();
    set_req(1, 64'h1004, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mis_rdy: rdy=%b want 0010", req_ready);
    end
    @(negedge aclk);
    req_valid = '0;
    checks++;
    if (err !== 4'b0010 || mv_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mis_err: err=%b v=%b b=%b want 0010/0/0",
               err, mv_valid, busy);
    end
    @(negedge aclk);
    checks++;
    if (err !== '0 || mv_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mis_after: err=%b v=%b b=%b want 0/0/0",
               err, mv_valid, busy);
    end
  endtask

  task automatic test_rerequest();
    int n = 0;
    mv_lat = 2;
    set_req(3, 64'h3000, 1'b1);
    @(negedge aclk);
    req_valid = '0;
    while (done === '0 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (done !== 4'b1000) begin
      errors++;
      $display("FAIL rereq_done: done=%b want 1000", done);
    end
    set_req(3, 64'h3008, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rereq_rdy: rdy=%b want 1000", req_ready);
    end
    @(negedge aclk);
    req_valid = '0;
    checks++;
    if (mv_valid !== 1'b1 || mv_dest !== 64'h3008 || done !== '0) begin
      errors++;
      $display("FAIL rereq_issue: v=%b d=%h done=%b want 1/3008/0",
               mv_valid, mv_dest, done);
    end
    drain();
  endtask

  task automatic test_issue_wait();
    mv_hold = 1'b1;
    repeat (2) @(negedge aclk);
    set_req(0, 64'h40, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wait_rdy: rdy=%b want 0001", req_ready);
    end
    @(negedge aclk);
    req_valid = '0;
    repeat (5) begin
      checks++;
      if (mv_valid !== 1'b1 || mv_dest !== 64'h40 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_hold: v=%b d=%h b=%b want 1/40/1",
                 mv_valid, mv_dest, busy);
      end
      @(negedge aclk);
    end
    mv_hold = 1'b0;
    drain();
  endtask

  task automatic test_watchdog();
    int k = 0;
    int n = 0;
    timeout_clr = 1'b1;
    @(negedge aclk);
    timeout_clr = 1'b0;
    mv_lat = 40;
    set_req(1, 64'h2000, 1'b1);
    @(negedge aclk);
    req_valid = '0;
    while (done === '0 && n < 200) begin
      if (busy && !mv_valid) k++;
      if (k == 16 || k == 17) begin
        checks++;
        if (timeout !== (k == 17)) begin
          errors++;
          $display("FAIL wd_edge: busy_cyc=%0d timeout=%b want %b",
                   k, timeout, k == 17);
        end
      end
      @(negedge aclk);
      n++;
    end
    checks++;
    if (done !== 4'b0010 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL wd_done: done=%b t=%b want 0010/1", done, timeout);
    end
    timeout_clr = 1'b1;
    @(negedge aclk);
    timeout_clr = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_clr: t=%b want 0", timeout);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mv_lat = 30;
    set_req(0, 64'h500, 1'b1);
    @(negedge aclk);
    req_valid = '0;
    repeat (5) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== '0 || mv_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_state: b=%b g=%b v=%b want 0",
               busy, grant, mv_valid);
    end
    checks++;
    if (mv_dest !== '0 || grant_id !== '0 || done !== '0) begin
      errors++;
      $display("FAIL rmid_regs: d=%h id=%0d done=%b want 0",
               mv_dest, grant_id, done);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      checks++;
      if (done !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rmid_quiet: done=%b b=%b want 0/0", done, busy);
      end
    end
    mv_lat = 2;
    set_req(0, 64'h600, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_rdy: rdy=%b want 0001", req_ready);
    end
    @(negedge aclk);
    req_valid = '0;
    checks++;
    if (mv_valid !== 1'b1 || mv_dest !== 64'h600) begin
      errors++;
      $display("FAIL rmid_issue: v=%b d=%h want 1/600", mv_valid, mv_dest);
    end
    while (done === '0 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_done: done=%b want 0001", done);
    end
    @(negedge aclk);
  endtask

  task automatic test_random();
    logic [63:0] adr[N];
    bit          vld[N];
    bit          outst[N];
    int          last = N - 1;
    int          stage = 0;
    int          owner = 0;
    int          drop = -1;
    int          w;
    int          j;
    logic [N-1:0] e_err = '0;
    logic [N-1:0] e_done = '0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_rdy;
    logic [1:0]   e_gid = '0;
    logic [63:0]  e_dest = '0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      outst[i] = 1'b0;
      adr[i] = '0;
    end
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    mv_rand = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge aclk);
      if (drop >= 0) begin
        req_valid[drop] = 1'b0;
        drop = -1;
      end
      checks++;
      if (err !== e_err || done !== e_done) begin
        errors++;
        $display("FAIL rnd_pulse: cyc=%0d err=%b done=%b want %b/%b",
                 cyc, err, done, e_err, e_done);
      end
      checks++;
      if (mv_valid !== (stage == 1) || busy !== (stage != 0)) begin
        errors++;
        $display("FAIL rnd_state: cyc=%0d v=%b b=%b want %b/%b",
                 cyc, mv_valid, busy, stage == 1, stage != 0);
      end
      checks++;
      if (grant !== e_grant || grant_id !== e_gid || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rnd_grant: cyc=%0d g=%b id=%0d t=%b want %b/%0d/0",
                 cyc, grant, grant_id, timeout, e_grant, e_gid);
      end
      if (stage == 1) begin
        checks++;
        if (mv_dest !== e_dest) begin
          errors++;
          $display("FAIL rnd_dest: d=%h want %h", mv_dest, e_dest);
        end
      end
      for (int i = 0; i < N; i++)
        if (e_err[i] || e_done[i]) outst[i] = 1'b0;
      if (cyc < 1800) begin
        for (int i = 0; i < N; i++) begin
          if (!vld[i] && !outst[i] && $urandom_range(0, 3) == 0) begin
            adr[i] = {$urandom, $urandom} & ~64'h7;
            if ($urandom_range(0, 4) == 0)
              adr[i] = adr[i] | 64'($urandom_range(1, 7));
            vld[i] = 1'b1;
            set_req(i, adr[i], 1'b1);
          end
        end
      end
      #1;
      w = -1;
      if (stage == 0) begin
        for (int k = 1; k <= N; k++) begin
          j = (last + k) % N;
          if (w < 0 && vld[j]) w = j;
        end
      end
      e_rdy = (w < 0) ? '0 : 4'(1 << w);
      checks++;
      if (req_ready !== e_rdy) begin
        errors++;
        $display("FAIL rnd_rdy: cyc=%0d rdy=%b want %b",
                 cyc, req_ready, e_rdy);
      end
      e_err = '0;
      e_done = '0;
      if (stage == 0) begin
        e_grant = '0;
        e_gid = '0;
        if (w >= 0) begin
          last = w;
          vld[w] = 1'b0;
          outst[w] = 1'b1;
          drop = w;
          if (adr[w][2:0] != 3'b000) begin
            e_err = 4'(1 << w);
          end else begin
            stage = 1;
            owner = w;
            e_dest = adr[w];
            e_grant = 4'(1 << w);
            e_gid = 2'(w);
          end
        end
      end else if (stage == 1) begin
        if (mv_ready) stage = 2;
      end else begin
        if (mv_ready) begin
          e_done = 4'(1 << owner);
          stage = 0;
        end
      end
    end
    mv_rand = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_all_rr();
    test_single();
    test_misaligned();
    test_rerequest();
    test_issue_wait();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
